rom_playback_sched: RTL

Sequencer and arbiter for the four-ROM serial playback datapath. It picks one of four switch requesters round-robin when `write` is pulsed and steps the ROM address through every word. It serialises each 8-bit word MSB-first onto a single output bit at a programmable bit rate, then signals completion. It replaces the ad-hoc holder/splitter/address-counter chain with one FSM that owns address, selection and bit timing.

---
 rtl/playback_pkg.sv | 25 ++
 rtl/rr_arbiter4.sv | 27 ++
 rtl/rom_playback_sched.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/playback_pkg.sv
// Shared state encoding, default geometry and helpers for the ROM playback sequencer.
package playback_pkg;

   localparam int unsigned BIT_DIV_DEF = 4;
   localparam int unsigned DEPTH_DEF   = 16;
   localparam int unsigned DATA_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Index of the set bit in a one-hot 4-bit vector (0 when none is set).
   function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick among four requesters, searching upward
// with wrap from the requester after last_grant.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] last_grant,
   output logic [3:0] gnt_c,
   output logic       valid_c
);

   logic [1:0] idx_c;
   logic       found_c;

   always_comb begin
      gnt_c   = 4'b0000;
      found_c = 1'b0;
      idx_c   = last_grant;
      for (int i = 1; i <= 4; i++) begin
         idx_c = last_grant + 2'(i);
         if (!found_c && req[idx_c]) begin
            gnt_c[idx_c] = 1'b1;
            found_c      = 1'b1;
         end
      end
      valid_c = found_c;
   end

endmodule

// File: rtl/rom_playback_sched.sv
// Four-ROM serial playback sequencer: arbitration, address stepping and MSB-first bit timing.
// Optional PLAYBACK_LOOP_EN: keep wrapping to word 0 while the granted switch stays on.
module rom_playback_sched
   import playback_pkg::*;
#(
   parameter int unsigned BIT_DIV = BIT_DIV_DEF,
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned DATA_W  = DATA_W_DEF
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              write,
   input  logic [3:0]        sw,
   input  logic [DATA_W-1:0] rom_data0,
   input  logic [DATA_W-1:0] rom_data1,
   input  logic [DATA_W-1:0] rom_data2,
   input  logic [DATA_W-1:0] rom_data3,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [3:0]        grant,
   output logic              out_bit,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [3:0]          grant_q, grant_d;
   logic                out_bit_q, out_bit_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [1:0]          last_grant_q, last_grant_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DIV_W-1:0]    div_q, div_d;

   logic [3:0]          arb_gnt_c;
   logic                arb_valid_c;
   logic [1:0]          gidx_c;
   logic [DATA_W-1:0]   sel_data_c;
   logic                sel_sw_c;
   logic                more_c;
   logic [ADDR_W-1:0]   addr_next_c;

   rr_arbiter4 u_arb (
      .req        (sw),
      .last_grant (last_grant_q),
      .gnt_c      (arb_gnt_c),
      .valid_c    (arb_valid_c)
   );

   assign gidx_c      = onehot_to_idx(grant_q);
   assign sel_sw_c    = sw[gidx_c];
   assign addr_next_c = (rom_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : rom_addr_q + ADDR_W'(1);

   // Address has already been prefetched at bit 0, so 0 here means the last word just played.
`ifdef PLAYBACK_LOOP_EN
   assign more_c = 1'b1;
`else
   assign more_c = (rom_addr_q != '0);
`endif

   always_comb begin
      unique case (gidx_c)
         2'd0:    sel_data_c = rom_data0;
         2'd1:    sel_data_c = rom_data1;
         2'd2:    sel_data_c = rom_data2;
         default: sel_data_c = rom_data3;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      grant_d      = grant_q;
      out_bit_d    = out_bit_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      last_grant_d = last_grant_q;
      word_d       = word_q;
      cnt_d        = cnt_q;
      div_d        = div_q;
      unique case (state_q)
         IDLE: begin
            if (write && arb_valid_c) begin
               state_d    = LOAD;
               grant_d    = arb_gnt_c;
               rom_addr_d = '0;
               busy_d     = 1'b1;
            end
         end
         LOAD: begin
            state_d   = SHIFT;
            word_d    = sel_data_c;
            out_bit_d = sel_data_c[DATA_W-1];
            cnt_d     = CNT_W'(DATA_W - 1);
            div_d     = '0;
         end
         SHIFT: begin
            if (div_q != DIV_W'(BIT_DIV - 1)) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (cnt_q != '0) begin
                  cnt_d     = cnt_q - CNT_W'(1);
                  out_bit_d = word_q[cnt_d];
                  if (cnt_q == CNT_W'(1)) rom_addr_d = addr_next_c;
               end else if (sel_sw_c && more_c) begin
                  // Seamless hand-over to the prefetched word.
                  word_d    = sel_data_c;
                  out_bit_d = sel_data_c[DATA_W-1];
                  cnt_d     = CNT_W'(DATA_W - 1);
               end else begin
                  state_d   = DONE;
                  out_bit_d = 1'b0;
                  done_d    = 1'b1;
               end
            end
         end
         DONE: begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            grant_d      = '0;
            last_grant_d = gidx_c;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rom_addr_q   <= '0;
         grant_q      <= '0;
         out_bit_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         last_grant_q <= 2'd3;
         word_q       <= '0;
         cnt_q        <= '0;
         div_q        <= '0;
      end else begin
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         grant_q      <= grant_d;
         out_bit_q    <= out_bit_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         last_grant_q <= last_grant_d;
         word_q       <= word_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign grant    = grant_q;
   assign out_bit  = out_bit_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
